// File: rtl/rr4_datapath_arbiter.sv
// Round-robin arbiter sharing one N-bit output register among 4 requesters; one-cycle gnt pulse to the winner.
// Latency: req sampled in T -> out_valid/gnt in T+1; out_ready=0 holds the word (req/data ignored while held).
module rr4_datapath_arbiter #(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  input  logic [N-1:0] data2,
  input  logic [N-1:0] data3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [1:0]   last_q;
  logic [1:0]   win;
  logic         load;
  logic [N-1:0] win_data;

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    win   = last_q;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_data = data0;
    case (win)
      2'd0: win_data = data0;
      2'd1: win_data = data1;
      2'd2: win_data = data2;
      2'd3: win_data = data3;
      default: win_data = data0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == HOLD);
      gnt       <= load ? (4'b0001 << win) : 4'b0000;
      if (load) begin
        out_data <= win_data;
        sel      <= win;
        last_q   <= win;
      end
    end
  end

endmodule

// File: tb/tb_rr4_datapath_arbiter.sv
// Directed bench for rr4_datapath_arbiter: expected grants are queued by the stimulus, popped by a monitor.
module tb_rr4_datapath_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data0, data1, data2, data3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  typedef struct packed {
    logic [3:0]  g;
    logic [1:0]  s;
    logic [63:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  rr4_datapath_arbiter #(.N(64)) dut (
    .clock(clock), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic expect_grant(input int w, input logic [63:0] d);
    exp_t e;
    e.g = 4'b0001 << w;
    e.s = 2'(w);
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every gnt pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (!done && gnt !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", {60'd0, gnt}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_gnt", {60'd0, gnt}, {60'd0, e.g});
        chk("mon_sel", {62'd0, sel}, {62'd0, e.s});
        chk("mon_data", out_data, e.d);
        chk("mon_valid", {63'd0, out_valid}, 64'd1);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
    data0 = 64'd0; data1 = 64'd0; data2 = 64'd0; data3 = 64'd0;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_gnt", {60'd0, gnt}, 64'd0);
      chk("rst_sel", {62'd0, sel}, 64'd0);
      chk("rst_data", out_data, 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_gnt", {60'd0, gnt}, 64'd0);

    // Single request from requester 2
    req = 4'b0100; data2 = 64'hDEAD_BEEF_0000_0002; out_ready = 1'b1;
    expect_grant(2, 64'hDEAD_BEEF_0000_0002);
    @(negedge clock);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    req = 4'b0000;
    @(negedge clock);
    chk("single_done_valid", {63'd0, out_valid}, 64'd0);
    chk("single_done_gnt", {60'd0, gnt}, 64'd0);

    // Fresh reset, then full rotation with all requesters active
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    data0 = 64'd0; data1 = 64'd1; data2 = 64'd2; data3 = 64'd3;
    req = 4'b1111; out_ready = 1'b1;
    expect_grant(0, 64'd0);
    expect_grant(1, 64'd1);
    expect_grant(2, 64'd2);
    expect_grant(3, 64'd3);
    expect_grant(0, 64'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      chk("rot_gnt_active", {63'd0, (gnt != 4'b0000)}, {63'd0, k[0]});
    end
    req = 4'b0000;

    // Backpressure on requester 1; req change during HOLD is ignored
    req = 4'b0010; data1 = 64'h11; data3 = 64'h33; out_ready = 1'b0;
    expect_grant(1, 64'h11);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data", out_data, 64'h11);
      chk("bp_sel", {62'd0, sel}, 64'd1);
      if (k > 1) chk("bp_gnt_low", {60'd0, gnt}, 64'd0);
      req = 4'b1000;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_gnt", {60'd0, gnt}, 64'd0);
    expect_grant(3, 64'h33);
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    chk("bp_g3_done", {63'd0, out_valid}, 64'd0);

    // Priority after wrap: last=3, req=1010 -> 1 then 3
    req = 4'b1010; data1 = 64'hA1; data3 = 64'hA3;
    expect_grant(1, 64'hA1);
    expect_grant(3, 64'hA3);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    chk("wrap_idle", {63'd0, out_valid}, 64'd0);

    // Reset while holding a word
    req = 4'b0100; data2 = 64'h2222; out_ready = 1'b0;
    expect_grant(2, 64'h2222);
    @(negedge clock);
    chk("midhold_valid", {63'd0, out_valid}, 64'd1);
    req = 4'b0000; reset = 1'b1;
    @(negedge clock);
    chk("midhold_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("midhold_rst_data", out_data, 64'd0);
    chk("midhold_rst_sel", {62'd0, sel}, 64'd0);
    chk("midhold_rst_gnt", {60'd0, gnt}, 64'd0);
    reset = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    data0 = 64'hF0; data1 = 64'hF1; data2 = 64'hF2; data3 = 64'hF3;
    expect_grant(0, 64'hF0);
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    @(negedge clock);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
